// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - funct codes the unit decodes from its ctl bus
//   - FSM state type for muldiv_unit
//   - MULDIV_ITERS: number of single-bit iterations per mul/div
package mips_pkg;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    localparam int unsigned MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single-iteration kernel for muldiv_unit.
//   i_is_div  1         1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc     2*WIDTH   current accumulator
//                         multiply: {partial product, remaining multiplier bits}
//                         divide:   {partial remainder, remaining dividend / quotient bits}
//   i_opnd    WIDTH     multiplicand (multiply) or divisor (divide)
//   o_acc     2*WIDTH   accumulator after one iteration
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set; the carry is kept and shifted back in.
    assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (i_acc[0] ? i_opnd : {WIDTH{1'b0}})};

    // Divide: trial subtract against the remainder shifted left by one.
    // The top bit of the difference is set exactly when the trial underflows.
    assign w_diff = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};

    always_comb begin
        o_acc = i_acc;
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// Optional feature macro: MULDIV_SIGNED_EN (adds MULT/DIV; otherwise those
// funct codes are ignored).
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   issue strobe, sampled with ctl/a/b while idle
//   ctl       in   6-bit funct code (MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU)
//   a         in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b         in   rt operand (multiplier / divisor)
//   busy      out  arithmetic operation in flight
//   done      out  one-cycle pulse in the cycle HI/LO take a new result
//   div_zero  out  sticky divide-by-zero flag, cleared by next accepted mul/div
//   hi, lo    out  architectural HI/LO
//   result    out  combinational MFHI/MFLO read data, 0 for other codes
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(MULDIV_ITERS);
    localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_ITERS - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient negated in FIX
    logic               r_neg_rem;   // remainder negated in FIX
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic               w_md_ctl;
    logic               w_signed_ctl;
    logic               w_is_div_ctl;
    logic               w_accept;
    logic               w_dz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULDIV_SIGNED_EN
    assign w_signed_ctl = (ctl == FN_MULT) || (ctl == FN_DIV);
    assign w_md_ctl     = w_signed_ctl || (ctl == FN_MULTU) || (ctl == FN_DIVU);
`else
    assign w_signed_ctl = 1'b0;
    assign w_md_ctl     = (ctl == FN_MULTU) || (ctl == FN_DIVU);
`endif

    assign w_is_div_ctl = (ctl == FN_DIV) || (ctl == FN_DIVU);
    assign w_accept     = (r_state == ST_IDLE) && start && w_md_ctl;
    assign w_dz         = w_is_div_ctl && (b == '0);

    // RUN always works on magnitudes; signs are reapplied in FIX.
    assign w_mag_a = (w_signed_ctl && a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (w_signed_ctl && b[WIDTH-1]) ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step)
    );

    assign w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_dz ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath, counter and HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (ctl == FN_MTHI)) begin
                        r_hi <= a;
                    end
                    if (start && (ctl == FN_MTLO)) begin
                        r_lo <= a;
                    end
                    if (w_accept) begin
                        r_cnt      <= CNT_INIT;
                        r_is_div   <= w_is_div_ctl;
                        r_neg_res  <= w_signed_ctl && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem  <= w_signed_ctl && w_is_div_ctl && a[WIDTH-1];
                        r_div_zero <= w_dz;
                        if (w_dz) begin
                            // Skips RUN/FIX: accumulator already holds the HI/LO image.
                            r_acc <= {a, {WIDTH{1'b1}}};
                        end else if (w_is_div_ctl) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_acc <= {w_fix_hi, w_fix_lo};
                    end else if (r_neg_res) begin
                        r_acc <= -r_acc;
                    end
                end
                ST_DONE: begin
                    r_hi <= r_acc[2*WIDTH-1:WIDTH];
                    r_lo <= r_acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

    always_comb begin
        result = '0;
        if (ctl == FN_MFHI) begin
            result = r_hi;
        end else if (ctl == FN_MFLO) begin
            result = r_lo;
        end
    end

endmodule
